// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the parametrised serializer/deserializer.
// Bit-order encodings match the value presented on lsb_first at load time.
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bit_counter.sv
// Counts consumed bits of the current word; terminal flags the final bit.
// clear has priority over enable so a load always restarts at zero.
module bit_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/param_shift_register.sv
// Full-duplex serializer/deserializer: shifts a loaded word out bit by bit while
// capturing ser_in into the vacated end, then publishes the captured word.
module param_shift_register
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] par_in,
  input  logic             lsb_first,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic [WIDTH-1:0] par_out,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             done_q, done_d;

  logic             cnt_clear;
  logic             cnt_en;
  logic             cnt_term;
  logic [CNT_W-1:0] cnt_unused;
  logic [WIDTH-1:0] sr_shifted;

  bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .count   (cnt_unused),
    .terminal(cnt_term)
  );

  // A one-bit word has no neighbours to shift: the new bit simply replaces it.
  generate
    if (WIDTH == 1) begin : g_single
      assign sr_shifted = ser_in;
    end else begin : g_multi
      assign sr_shifted = (mode_q == LSB_FIRST) ? {ser_in, sr_q[WIDTH-1:1]}
                                                : {sr_q[WIDTH-2:0], ser_in};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    mode_d     = mode_q;
    par_out_d  = par_out_q;
    done_d     = 1'b0;
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    ser_last   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          sr_d      = par_in;
          mode_d    = lsb_first;
          cnt_clear = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = (mode_q == LSB_FIRST) ? sr_q[0] : sr_q[WIDTH-1];
        ser_last  = cnt_term;
        if (shift_en) begin
          sr_d   = sr_shifted;
          cnt_en = 1'b1;
          // Completion publishes the post-shift register, including the last ser_in bit.
          if (cnt_term) begin
            par_out_d = sr_shifted;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      mode_q    <= MSB_FIRST;
      par_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      mode_q    <= mode_d;
      par_out_q <= par_out_d;
      done_q    <= done_d;
    end
  end

  assign par_out = par_out_q;
  assign done    = done_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register at WIDTH 32 (loopback), 8 (random words) and 1.
module tb_param_shift_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int checks   = 0;
  int failures = 0;

  // WIDTH=32 instance, ser_in looped back from ser_out
  logic        lv32, lr32, lsb32, en32, si32, so32, sv32, sl32, dn32;
  logic [31:0] par32, po32;
  assign si32 = so32;

  // WIDTH=8 instance
  logic       lv8, lr8, lsb8, en8, si8, so8, sv8, sl8, dn8;
  logic [7:0] par8, po8;

  // WIDTH=1 instance
  logic       lv1, lr1, lsb1, en1, si1, so1, sv1, sl1, dn1;
  logic [0:0] par1, po1;

  param_shift_register #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .load_valid(lv32), .load_ready(lr32), .par_in(par32),
    .lsb_first(lsb32), .shift_en(en32), .ser_in(si32), .ser_out(so32),
    .ser_valid(sv32), .ser_last(sl32), .par_out(po32), .done(dn32));

  param_shift_register #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .load_valid(lv8), .load_ready(lr8), .par_in(par8),
    .lsb_first(lsb8), .shift_en(en8), .ser_in(si8), .ser_out(so8),
    .ser_valid(sv8), .ser_last(sl8), .par_out(po8), .done(dn8));

  param_shift_register #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(lr1), .par_in(par1),
    .lsb_first(lsb1), .shift_en(en1), .ser_in(si1), .ser_out(so1),
    .ser_valid(sv1), .ser_last(sl1), .par_out(po1), .done(dn1));

  // k-th transmitted bit of a w-bit word in the chosen order
  function automatic logic ref_bit(input logic [31:0] word, input int w, input logic lsb,
                                   input int k);
    return lsb ? word[k] : word[w-1-k];
  endfunction

  // Word assembled from received bits: first bit lands at MSB (MSB-first) or LSB (LSB-first)
  function automatic logic [31:0] ref_capture(input logic [31:0] rx, input int w,
                                              input logic lsb);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < w; k++) r[lsb ? k : w-1-k] = rx[k];
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({lr32, so32, sv32, sl32, dn32} !== 5'b10000 || po32 !== 32'h0) begin
      failures++;
      $display("FAIL reset_w32 got lr/so/sv/sl/dn=%b par_out=%h exp 10000 00000000",
               {lr32, so32, sv32, sl32, dn32}, po32);
    end
    checks++;
    if ({lr8, so8, sv8, sl8, dn8} !== 5'b10000 || po8 !== 8'h0) begin
      failures++;
      $display("FAIL reset_w8 got lr/so/sv/sl/dn=%b par_out=%h exp 10000 00",
               {lr8, so8, sv8, sl8, dn8}, po8);
    end
    checks++;
    if ({lr1, so1, sv1, sl1, dn1, po1} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_w1 got %b exp 100000", {lr1, so1, sv1, sl1, dn1, po1});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One complete WIDTH=8 word starting from idle at a falling edge; ends in the done cycle.
  task automatic word8(input logic [7:0] par, input logic lsb, input logic [7:0] rx,
                       input int stall_before, input int stall_len, input string tag);
    logic [31:0] exp_po;
    checks++;
    if (lr8 !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready got %b exp 1", tag, lr8);
    end
    lv8 = 1'b1; par8 = par; lsb8 = lsb; en8 = 1'b0;
    @(negedge clk);
    lv8 = 1'b0; par8 = 8'($urandom); lsb8 = 1'($urandom);
    for (int k = 0; k < 8; k++) begin
      if (k == stall_before) begin
        for (int s = 0; s < stall_len; s++) begin
          en8 = 1'b0; lv8 = (s == 1); si8 = 1'($urandom);
          checks++;
          if ({sv8, so8, sl8, dn8, lr8} !== {1'b1, ref_bit(32'(par), 8, lsb, k), k == 7, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s_stall k=%0d s=%0d got sv/so/sl/dn/lr=%b exp %b", tag, k, s,
                     {sv8, so8, sl8, dn8, lr8},
                     {1'b1, ref_bit(32'(par), 8, lsb, k), k == 7, 1'b0, 1'b0});
          end
          @(negedge clk);
        end
        lv8 = 1'b0;
      end
      en8 = 1'b1; si8 = rx[k];
      checks++;
      if ({sv8, so8, sl8, dn8, lr8} !== {1'b1, ref_bit(32'(par), 8, lsb, k), k == 7, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s_bit k=%0d got sv/so/sl/dn/lr=%b exp %b", tag, k,
                 {sv8, so8, sl8, dn8, lr8},
                 {1'b1, ref_bit(32'(par), 8, lsb, k), k == 7, 1'b0, 1'b0});
      end
      @(negedge clk);
    end
    en8 = 1'b0;
    exp_po = ref_capture(32'(rx), 8, lsb);
    checks++;
    if ({dn8, sv8, lr8} !== 3'b101 || po8 !== exp_po[7:0]) begin
      failures++;
      $display("FAIL %s_done got dn/sv/lr=%b par_out=%h exp 101 %h", tag,
               {dn8, sv8, lr8}, po8, exp_po[7:0]);
    end
  endtask

  task automatic test_msb_loopback();
    lv32 = 1'b1; par32 = 32'hA5C3_0F81; lsb32 = 1'b0; en32 = 1'b1;
    @(negedge clk);
    lv32 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if ({sv32, so32, sl32, dn32} !== {1'b1, ref_bit(32'hA5C3_0F81, 32, 1'b0, k), k == 31, 1'b0}) begin
        failures++;
        $display("FAIL loop32_bit cycle=%0d got sv/so/sl/dn=%b exp %b", k + 1,
                 {sv32, so32, sl32, dn32},
                 {1'b1, ref_bit(32'hA5C3_0F81, 32, 1'b0, k), k == 31, 1'b0});
      end
      @(negedge clk);
    end
    checks++;
    if (dn32 !== 1'b1 || po32 !== 32'hA5C3_0F81) begin
      failures++;
      $display("FAIL loop32_done cycle=33 got dn=%b par_out=%h exp 1 a5c30f81", dn32, po32);
    end
    en32 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsb_loopback_random();
    logic [31:0] w;
    w = $urandom;
    lv32 = 1'b1; par32 = w; lsb32 = 1'b1; en32 = 1'b1;
    @(negedge clk);
    lv32 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (so32 !== ref_bit(w, 32, 1'b1, k)) begin
        failures++;
        $display("FAIL loop32_lsb_bit k=%0d got %b exp %b", k, so32, ref_bit(w, 32, 1'b1, k));
      end
      @(negedge clk);
    end
    checks++;
    if (dn32 !== 1'b1 || po32 !== w) begin
      failures++;
      $display("FAIL loop32_lsb_done got dn=%b par_out=%h exp 1 %h", dn32, po32, w);
    end
    en32 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsb_external();
    word8(8'h01, 1'b1, 8'b0000_1101, -1, 0, "lsb_ext");
    checks++;
    if (po8 !== 8'h0D) begin
      failures++;
      $display("FAIL lsb_ext_value got %h exp 0d", po8);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    word8(8'($urandom), 1'b0, 8'($urandom), 3, 3, "stall_msb");
    @(negedge clk);
    word8(8'($urandom), 1'b1, 8'($urandom), 6, 2, "stall_lsb");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    word8(8'hC3, 1'b0, 8'hFF, -1, 0, "b2b_first");
    word8(8'($urandom), 1'($urandom), 8'hFF, -1, 0, "b2b_second");
    @(negedge clk);
    checks++;
    if (dn8 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done_width got %b exp 0", dn8);
    end
    // Abandon a word after five bits with reset; par_out must clear and done stay low.
    lv8 = 1'b1; par8 = 8'h5A; lsb8 = 1'b0;
    @(negedge clk);
    lv8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      en8 = 1'b1; si8 = 1'($urandom);
      @(negedge clk);
    end
    checks++;
    if (so8 !== ref_bit(32'h5A, 8, 1'b0, 5) || sv8 !== 1'b1) begin
      failures++;
      $display("FAIL midreset_bit5 got so/sv=%b%b exp %b1", so8, sv8, ref_bit(32'h5A, 8, 1'b0, 5));
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({lr8, so8, sv8, sl8, dn8} !== 5'b10000 || po8 !== 8'h0) begin
      failures++;
      $display("FAIL midreset_state got lr/so/sv/sl/dn=%b par_out=%h exp 10000 00",
               {lr8, so8, sv8, sl8, dn8}, po8);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({dn8, sv8} !== 2'b00) begin
        failures++;
        $display("FAIL midreset_nodone c=%0d got dn/sv=%b exp 00", c, {dn8, sv8});
      end
      @(negedge clk);
    end
    en8 = 1'b0;
  endtask

  task automatic test_reset_idle();
    word8(8'h81, 1'b1, 8'hA7, -1, 0, "pre_idle_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({lr8, so8, sv8, sl8, dn8} !== 5'b10000 || po8 !== 8'h0) begin
      failures++;
      $display("FAIL idle_reset got lr/so/sv/sl/dn=%b par_out=%h exp 10000 00",
               {lr8, so8, sv8, sl8, dn8}, po8);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    int st, sl, gap;
    for (int i = 0; i < 20; i++) begin
      st  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      sl  = int'($urandom_range(1, 3));
      gap = int'($urandom_range(0, 2));
      word8(8'($urandom), 1'($urandom), 8'($urandom), st, sl, "rand");
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if ({dn8, sv8, lr8} !== 3'b001) begin
          failures++;
          $display("FAIL rand_gap i=%0d got dn/sv/lr=%b exp 001", i, {dn8, sv8, lr8});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_width1();
    lv1 = 1'b1; par1 = 1'b1; lsb1 = 1'b0; en1 = 1'b0;
    @(negedge clk);
    lv1 = 1'b0;
    checks++;
    if ({sv1, so1, sl1, dn1} !== 4'b1110) begin
      failures++;
      $display("FAIL w1_bit got sv/so/sl/dn=%b exp 1110", {sv1, so1, sl1, dn1});
    end
    en1 = 1'b1; si1 = 1'b0;
    @(negedge clk);
    en1 = 1'b0;
    checks++;
    if ({dn1, sv1, po1} !== 3'b100) begin
      failures++;
      $display("FAIL w1_done got dn/sv/par_out=%b exp 100", {dn1, sv1, po1});
    end
    lv1 = 1'b1; par1 = 1'b0; lsb1 = 1'b1;
    @(negedge clk);
    lv1 = 1'b0;
    checks++;
    if ({sv1, so1, sl1, dn1} !== 4'b1010) begin
      failures++;
      $display("FAIL w1_bit2 got sv/so/sl/dn=%b exp 1010", {sv1, so1, sl1, dn1});
    end
    en1 = 1'b1; si1 = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    checks++;
    if ({dn1, sv1, po1} !== 3'b101) begin
      failures++;
      $display("FAIL w1_done2 got dn/sv/par_out=%b exp 101", {dn1, sv1, po1});
    end
    @(negedge clk);
  endtask

  initial begin
    lv32 = 1'b0; par32 = '0; lsb32 = 1'b0; en32 = 1'b0;
    lv8  = 1'b0; par8  = '0; lsb8  = 1'b0; en8  = 1'b0; si8 = 1'b0;
    lv1  = 1'b0; par1  = '0; lsb1  = 1'b0; en1  = 1'b0; si1 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_msb_loopback();
    test_lsb_loopback_random();
    test_lsb_external();
    test_stall();
    test_back_to_back();
    test_reset_idle();
    test_random();
    test_width1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
